// File: rtl/csr_port_arbiter_if.sv
// csr_port_arbiter_if: requester handshake and CSR-port signals of csr_port_arbiter.
// master = requester/CSR-file side, slave = the arbiter itself.
interface csr_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*2-1:0]  req_op;
  logic [NUM_REQ*12-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  csr_rd_en;
  logic                  csr_explicit_rd;
  logic                  csr_wr_en;
  logic [11:0]           csr_addr;
  logic [31:0]           csr_wr_data;
  logic [31:0]           csr_rd_data;
  logic                  csr_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, csr_rd_data, csr_illegal,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           csr_rd_en, csr_explicit_rd, csr_wr_en, csr_addr, csr_wr_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, csr_rd_data, csr_illegal,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           csr_rd_en, csr_explicit_rd, csr_wr_en, csr_addr, csr_wr_data
  );
endinterface

// File: rtl/csr_port_arbiter.sv
// csr_port_arbiter: shares the CSR file port among NUM_REQ requesters and turns
// each READ/WRITE/SET/CLEAR request into an atomic read -> optional write sequence.
// Optional macro CSR_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed priority, index 0 highest).
module csr_port_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input logic             clk,
  input logic             rst_n,
  csr_port_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_SET = 2'b10, OP_CLEAR = 2'b11} op_e;

  state_e        state, state_nxt;
  logic [IW-1:0] owner;
  op_e           op;
  logic [11:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          err;

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic          handshake;
  logic          write_eff;
  logic          read_err;

`ifdef CSR_ARB_ROUND_ROBIN_EN
  // rr_ptr holds the index with top priority (last granted owner + 1), so the
  // search below naturally starts just after the previous winner.
  logic [IW-1:0] rr_ptr;

  // Round-robin winner: first valid index at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer advances past the winner only on an actual handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  // Fixed priority winner: lowest valid index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[IW'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(k);
      end
    end
  end
`endif

  assign handshake = (state == S_IDLE) && grant_found;

  // Write effect and fault decode of the latched request.
  always_comb begin
    write_eff = (op == OP_WRITE) || (((op == OP_SET) || (op == OP_CLEAR)) && (wdata != '0));
    read_err  = bus.csr_illegal || ((op != OP_READ) && write_eff && (addr[11:10] == 2'b11));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request payload captured at handshake; CSR read result captured in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
      op    <= OP_READ;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (handshake) begin
        owner <= grant_idx;
        op    <= op_e'(bus.req_op[32'(grant_idx)*2 +: 2]);
        addr  <= bus.req_addr[32'(grant_idx)*12 +: 12];
        wdata <= bus.req_wdata[32'(grant_idx)*32 +: 32];
      end
      if (state == S_READ) begin
        rdata <= bus.csr_rd_data;
        err   <= read_err;
      end
    end
  end

  // Next state and all port outputs.
  always_comb begin
    state_nxt           = state;
    bus.req_ready       = '0;
    bus.rsp_valid       = '0;
    bus.rsp_rdata       = '0;
    bus.rsp_err         = 1'b0;
    bus.csr_rd_en       = 1'b0;
    bus.csr_explicit_rd = 1'b0;
    bus.csr_wr_en       = 1'b0;
    bus.csr_addr        = '0;
    bus.csr_wr_data     = '0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          bus.req_ready[grant_idx] = 1'b1;
          state_nxt                = S_READ;
        end
      end
      S_READ: begin
        bus.csr_rd_en       = 1'b1;
        bus.csr_explicit_rd = 1'b1;
        bus.csr_addr        = addr;
        state_nxt           = (write_eff && !read_err) ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        bus.csr_wr_en = 1'b1;
        bus.csr_addr  = addr;
        case (op)
          OP_SET:   bus.csr_wr_data = rdata | wdata;
          OP_CLEAR: bus.csr_wr_data = rdata & ~wdata;
          default:  bus.csr_wr_data = wdata;
        endcase
        state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid[owner] = 1'b1;
        bus.rsp_rdata        = rdata;
        bus.rsp_err          = err;
        state_nxt            = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_csr_port_arbiter.sv
// tb_csr_port_arbiter: self-checking bench for csr_port_arbiter with a simple CSR
// file model and a transaction-level reference model of request outcomes.
`timescale 1ns/1ps
module tb_csr_port_arbiter;
  localparam int unsigned NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  csr_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  csr_port_arbiter #(.NUM_REQ(NUM_REQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // CSR file model: 0x7B0 is illegal (reads as 0 with illegal flag).
  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        preset_en = 1'b0;
  logic [11:0] preset_addr = '0;
  logic [31:0] preset_data = '0;

  function automatic bit is_illegal(input logic [11:0] a);
    return a == 12'h7B0;
  endfunction

  assign bus.csr_illegal = bus.csr_rd_en && is_illegal(bus.csr_addr);
  assign bus.csr_rd_data = (bus.csr_rd_en && !is_illegal(bus.csr_addr)) ? csr_mem[bus.csr_addr] : '0;

  always @(posedge clk) begin
    if (preset_en) csr_mem[preset_addr] <= preset_data;
    else if (bus.csr_wr_en) csr_mem[bus.csr_addr] <= bus.csr_wr_data;
  end

  // Reference outcome of one request against the expected CSR contents.
  function automatic void predict(input int op, input logic [11:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err, output bit wr,
                                  output logic [31:0] nv, output int lat);
    logic [31:0] old;
    bit eff;
    old = is_illegal(a) ? 32'h0 : ref_mem[a];
    eff = (op == 1) || (op >= 2 && wd != 0);
    rd  = old;
    err = is_illegal(a) || (op != 0 && eff && a[11:10] == 2'b11);
    wr  = eff && !err;
    case (op)
      1:       nv = wd;
      2:       nv = old | wd;
      3:       nv = old & ~wd;
      default: nv = old;
    endcase
    lat = wr ? 3 : 2;
  endfunction

  task automatic set_req(input int r, input bit v, input int op, input logic [11:0] a, input logic [31:0] wd);
    bus.req_valid[r]          = v;
    bus.req_op[r*2 +: 2]      = 2'(op);
    bus.req_addr[r*12 +: 12]  = a;
    bus.req_wdata[r*32 +: 32] = wd;
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    preset_en = 1'b1; preset_addr = a; preset_data = d; ref_mem[a] = d;
    @(negedge clk);
    preset_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issues one request and observes what happens on the CSR and response ports.
  // Called at a negedge, returns at a negedge; lat=0 means no handshake/response.
  task automatic run_op(input int r, input int op, input logic [11:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err, output int nwr,
                        output logic [31:0] wdo, output logic [NUM_REQ-1:0] rspv, output bit rd1);
    int w;
    lat = 0; rd = '0; err = 1'b0; nwr = 0; wdo = '0; rspv = '0; rd1 = 1'b0;
    set_req(r, 1, op, a, wd);
    #1;
    w = 0;
    while (!bus.req_ready[r] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (!bus.req_ready[r]) begin
      set_req(r, 0, 0, '0, '0);
      @(negedge clk);
      return;
    end
    @(posedge clk); #1;
    set_req(r, 0, int'($urandom_range(3)), 12'($urandom), $urandom);
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) rd1 = bus.csr_rd_en && bus.csr_explicit_rd && (bus.csr_addr == a) && !bus.csr_wr_en;
      if (bus.csr_wr_en) begin
        nwr++;
        wdo = bus.csr_wr_data;
        if (bus.csr_addr != a) nwr += 100;
      end
      if (bus.rsp_valid != '0) begin
        lat = c; rd = bus.rsp_rdata; err = bus.rsp_err; rspv = bus.rsp_valid;
        break;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat, nwr; logic [31:0] rd, wdo; logic err; logic [NUM_REQ-1:0] rspv; bit rd1;
    logic [31:0] erd, env; logic eerr; bit ewr; int elat;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.csr_rd_en, bus.csr_explicit_rd,
         bus.csr_wr_en, bus.csr_addr, bus.csr_wr_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs exp all 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
    preset(12'h300, 32'h1880);
    set_req(0, 1, 2, 12'h300, 32'h8);
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL reset_ready got %b exp 01", bus.req_ready); end
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    @(posedge clk); #1;
    checks++;
    if (bus.csr_wr_en !== 1'b1 || bus.csr_wr_data !== 32'h1888) begin
      errors++; $display("FAIL reset_midwrite got wr_en=%b data=%h exp 1 00001888", bus.csr_wr_en, bus.csr_wr_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.csr_rd_en, bus.csr_explicit_rd,
         bus.csr_wr_en, bus.csr_addr, bus.csr_wr_data} !== '0) begin
      errors++; $display("FAIL reset_abort got wr_en=%b addr=%h exp all 0", bus.csr_wr_en, bus.csr_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (csr_mem[12'h300] !== 32'h1880) begin errors++; $display("FAIL reset_no_write got %h exp 00001880", csr_mem[12'h300]); end
    rst_n = 1'b1;
    @(negedge clk);
    predict(0, 12'h340, '0, erd, eerr, ewr, env, elat);
    run_op(0, 0, 12'h340, '0, lat, rd, err, nwr, wdo, rspv, rd1);
    checks++;
    if (lat !== elat || rd !== erd || err !== eerr || nwr !== 0) begin
      errors++; $display("FAIL reset_after_read got lat=%0d rd=%h err=%b nwr=%0d exp lat=%0d rd=%h err=%b nwr=0",
                         lat, rd, err, nwr, elat, erd, eerr);
    end
  endtask

  task automatic test_read();
    int lat, nwr; logic [31:0] rd, wdo; logic err; logic [NUM_REQ-1:0] rspv; bit rd1;
    run_op(0, 0, 12'hF11, '0, lat, rd, err, nwr, wdo, rspv, rd1);
    checks++;
    if (rd1 !== 1'b1) begin errors++; $display("FAIL read_rd_en_T1 got %b exp 1", rd1); end
    checks++;
    if (lat !== 2 || rspv !== 2'b01) begin errors++; $display("FAIL read_latency got lat=%0d rspv=%b exp 2 01", lat, rspv); end
    checks++;
    if (rd !== 32'h0 || err !== 1'b0 || nwr !== 0) begin
      errors++; $display("FAIL read_data got rd=%h err=%b nwr=%0d exp 0 0 0", rd, err, nwr);
    end
  endtask

  task automatic test_set();
    int lat, nwr; logic [31:0] rd, wdo; logic err; logic [NUM_REQ-1:0] rspv; bit rd1;
    preset(12'h300, 32'h1880);
    run_op(0, 2, 12'h300, 32'h8, lat, rd, err, nwr, wdo, rspv, rd1);
    ref_mem[12'h300] = 32'h1888;
    checks++;
    if (lat !== 3 || nwr !== 1 || wdo !== 32'h1888) begin
      errors++; $display("FAIL set_write got lat=%0d nwr=%0d wdata=%h exp 3 1 00001888", lat, nwr, wdo);
    end
    checks++;
    if (rd !== 32'h1880 || err !== 1'b0) begin errors++; $display("FAIL set_rdata got %h err=%b exp 00001880 0", rd, err); end
    run_op(0, 2, 12'h300, 32'h0, lat, rd, err, nwr, wdo, rspv, rd1);
    checks++;
    if (lat !== 2 || nwr !== 0 || rd !== 32'h1888) begin
      errors++; $display("FAIL set_zero got lat=%0d nwr=%0d rd=%h exp 2 0 00001888", lat, nwr, rd);
    end
  endtask

  task automatic test_faults();
    int lat, nwr; logic [31:0] rd, wdo; logic err; logic [NUM_REQ-1:0] rspv; bit rd1;
    preset(12'hC00, 32'h1234);
    run_op(1, 1, 12'hC00, 32'hDEAD, lat, rd, err, nwr, wdo, rspv, rd1);
    checks++;
    if (err !== 1'b1 || nwr !== 0 || lat !== 2 || rspv !== 2'b10 || rd !== 32'h1234) begin
      errors++; $display("FAIL ro_write got err=%b nwr=%0d lat=%0d rspv=%b rd=%h exp 1 0 2 10 00001234",
                         err, nwr, lat, rspv, rd);
    end
    run_op(0, 0, 12'h7B0, '0, lat, rd, err, nwr, wdo, rspv, rd1);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++; $display("FAIL illegal_read got err=%b rd=%h lat=%0d exp 1 0 2", err, rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    int got[$]; int tcyc[$]; int cyc; int ptr; int exp; logic [NUM_REQ-1:0] hs;
    do_reset();
    set_req(0, 1, 0, 12'h340, '0);
    set_req(1, 1, 0, 12'hF11, '0);
    cyc = 0;
    while (got.size() < 4 && cyc < 60) begin
      #1;
      hs = bus.req_valid & bus.req_ready;
      if (hs != '0) begin
        checks++;
        if ($countones(hs) != 1) begin errors++; $display("FAIL b2b_onehot got %b exp one bit", hs); end
        for (int i = NUM_REQ - 1; i >= 0; i--) if (hs[i]) exp = i;
        got.push_back(exp);
        tcyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 0, '0, '0);
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got.size()); end
    ptr = 0;
    for (int k = 0; k < got.size(); k++) begin
`ifdef CSR_ARB_ROUND_ROBIN_EN
      exp = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (((ptr + i) % NUM_REQ) < 2) exp = (ptr + i) % NUM_REQ;
      ptr = (exp + 1) % NUM_REQ;
`else
      exp = 0;
`endif
      checks++;
      if (got[k] != exp) begin errors++; $display("FAIL b2b_owner%0d got %0d exp %0d", k, got[k], exp); end
      if (k > 0) begin
        checks++;
        if (tcyc[k] - tcyc[k-1] != 3) begin errors++; $display("FAIL b2b_gap%0d got %0d exp 3", k, tcyc[k] - tcyc[k-1]); end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_atomic();
    int ord[$]; logic [31:0] rds[$]; int cyc; logic [NUM_REQ-1:0] hs;
    logic [31:0] erd0, erd1, env; logic eerr; bit ewr; int elat;
    do_reset();
    preset(12'h340, 32'hABCD);
    predict(3, 12'h340, 32'hF, erd0, eerr, ewr, env, elat);
    if (ewr) ref_mem[12'h340] = env;
    predict(1, 12'h340, 32'h5, erd1, eerr, ewr, env, elat);
    if (ewr) ref_mem[12'h340] = env;
    set_req(0, 1, 3, 12'h340, 32'hF);
    set_req(1, 1, 1, 12'h340, 32'h5);
    cyc = 0;
    while (ord.size() < 2 && cyc < 40) begin
      #1;
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) if (hs[i]) bus.req_valid[i] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (bus.rsp_valid[i]) begin ord.push_back(i); rds.push_back(bus.rsp_rdata); end
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 0, '0, '0);
    checks++;
    if (ord.size() != 2) begin
      errors++; $display("FAIL atomic_count got %0d exp 2", ord.size());
    end else begin
      checks++;
      if (ord[0] != 0 || rds[0] !== erd0) begin errors++; $display("FAIL atomic_first got owner=%0d rd=%h exp 0 %h", ord[0], rds[0], erd0); end
      checks++;
      if (ord[1] != 1 || rds[1] !== erd1) begin errors++; $display("FAIL atomic_second got owner=%0d rd=%h exp 1 %h", ord[1], rds[1], erd1); end
    end
    checks++;
    if (csr_mem[12'h340] !== 32'h5) begin errors++; $display("FAIL atomic_final got %h exp 00000005", csr_mem[12'h340]); end
  endtask

  task automatic test_random();
    logic [11:0] pool [6];
    int lat, nwr, r, op, elat; logic [31:0] rd, wdo, wd, erd, env; logic err, eerr; bit ewr, rd1;
    logic [NUM_REQ-1:0] rspv; logic [11:0] a;
    pool = '{12'h340, 12'h300, 12'hC00, 12'h7B0, 12'hF11, 12'h341};
    for (int n = 0; n < 40; n++) begin
      r  = int'($urandom_range(NUM_REQ - 1));
      op = int'($urandom_range(3));
      a  = pool[$urandom_range(5)];
      wd = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      predict(op, a, wd, erd, eerr, ewr, env, elat);
      if (ewr) ref_mem[a] = env;
      run_op(r, op, a, wd, lat, rd, err, nwr, wdo, rspv, rd1);
      checks++;
      if (lat !== elat || rspv !== NUM_REQ'(1 << r) || rd1 !== 1'b1) begin
        errors++; $display("FAIL rand%0d_timing got lat=%0d rspv=%b rd1=%b exp %0d %b 1", n, lat, rspv, rd1, elat, NUM_REQ'(1 << r));
      end
      checks++;
      if (rd !== erd || err !== eerr) begin
        errors++; $display("FAIL rand%0d_rsp op=%0d addr=%h got rd=%h err=%b exp %h %b", n, op, a, rd, err, erd, eerr);
      end
      checks++;
      if (nwr !== (ewr ? 1 : 0) || (ewr && wdo !== env)) begin
        errors++; $display("FAIL rand%0d_write got nwr=%0d data=%h exp %0d %h", n, nwr, wdo, ewr ? 1 : 0, env);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (csr_mem[pool[i]] !== ref_mem[pool[i]]) begin
        errors++; $display("FAIL rand_mem_%h got %h exp %h", pool[i], csr_mem[pool[i]], ref_mem[pool[i]]);
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    preset(12'h340, 32'h1111_2222);
    preset(12'h300, 32'h1880);
    preset(12'hC00, 32'h55);
    preset(12'h7B0, 32'h77);
    preset(12'hF11, 32'h0);
    preset(12'h341, 32'h8000_0004);
    test_reset();
    test_read();
    test_set();
    test_faults();
    test_back_to_back();
    test_atomic();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
